uart_rx_fifo_bridge: RTL and testbench

// - Buffers bytes from the UART receiver into a FIFO and exposes them to the picorv32 native memory bus
//   as a small register window (DATA/STATUS/CTRL).
// - Raises a level interrupt at a programmable fill level, so firmware never loses bytes between polls.
// - Upstream: UART byte receiver. Downstream: SoC address decoder and the core IRQ vector.

---
 rtl/uart_rx_fifo_bridge.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_bridge.sv
// uart_rx_fifo_bridge
// Buffers bytes from the UART receiver in a FIFO and exposes them to the picorv32 native
// memory bus as a three-register window, with a level interrupt at a programmable fill level.
//
// Ports:
//   clk        core clock, rising edge
//   rst        asynchronous reset, active-high
//   rx_data    received byte, valid while rx_valid=1
//   rx_valid   one-cycle strobe per received byte
//   bus_sel    decoder hit for this window
//   bus_addr   byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, others reserved
//   bus_wstrb  write strobes, 0000 = read
//   bus_wdata  write data
//   bus_rdata  read data, valid while bus_ready=1
//   bus_ready  one-cycle completion pulse, one cycle after the access is sampled
//   irq        level interrupt: irq_en && count >= thresh (registered)
module uart_rx_fifo_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        bus_sel,
  input  logic [3:0]  bus_addr,
  input  logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        irq
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  typedef enum logic {StIdle, StResp} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
  logic [8:0]            thresh_q, thresh_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            mem_q [Depth];

  logic       full, empty, accept, is_rd, sel_data, sel_status, sel_ctrl;
  logic       pop, push, flush, ovf_set, ovf_clr;
  logic [8:0] count9;
  logic       unused_wdata;

  assign unused_wdata = ^{bus_wdata[31:17], bus_wdata[7:2]};

  assign full       = (count_q == CntW'(Depth));
  assign empty      = (count_q == '0);
  assign count9     = 9'(count_q);
  assign accept     = (state_q == StIdle) && bus_sel;
  assign is_rd      = (bus_wstrb == 4'b0000);
  assign sel_data   = (bus_addr == 4'h0);
  assign sel_status = (bus_addr == 4'h4);
  assign sel_ctrl   = (bus_addr == 4'h8);

  assign pop     = accept && is_rd && sel_data && !empty;
  assign flush   = accept && !is_rd && sel_ctrl && bus_wstrb[0] && bus_wdata[1];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push    = rx_valid && !flush && (!full || pop);
  assign ovf_set = rx_valid && !flush && full && !pop;
  assign ovf_clr = accept && !is_rd && sel_status && bus_wstrb[1] && bus_wdata[15];

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      StIdle: if (accept) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      rdata_d = 32'h0;
      if (is_rd) begin
        if (sel_data) begin
          rdata_d = empty ? 32'h8000_0000 : {24'h0, mem_q[rd_ptr_q]};
        end else if (sel_status) begin
          rdata_d = {16'h0, ovf_q, full, empty, 4'h0, count9};
        end else if (sel_ctrl) begin
          rdata_d = {15'h0, thresh_q, 6'h0, 1'b0, irq_en_q};
        end
      end else if (sel_ctrl) begin
        if (bus_wstrb[0]) irq_en_d = bus_wdata[0];
        if (bus_wstrb[1]) thresh_d[7:0] = bus_wdata[15:8];
        if (bus_wstrb[2]) thresh_d[8] = bus_wdata[16];
      end
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Set wins over a same-cycle clear.
  assign ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  assign irq_d = irq_en_q && (count9 >= thresh_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      thresh_q <= 9'd1;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      thresh_q <= thresh_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign bus_ready = (state_q == StResp);
  assign bus_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_bridge.sv
// Directed bench for uart_rx_fifo_bridge (DEPTH_LOG2 = 4).
module tb_uart_rx_fifo_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        bus_sel = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [3:0]  bus_wstrb = 4'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        irq;

  int checks = 0;
  int failures = 0;

  uart_rx_fifo_bridge #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .bus_sel   (bus_sel),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus access; lat = cycles from sample edge to ready (bounded), rdy2 = ready one cycle later.
  task automatic bus_xfer(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output logic rdy2);
    @(negedge clk);
    bus_sel = 1'b1; bus_addr = a; bus_wstrb = s; bus_wdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_ready && lat < 4);
    rd = bus_rdata;
    bus_sel = 1'b0; bus_wstrb = 4'h0;
    @(posedge clk); #1;
    rdy2 = bus_ready;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; logic r2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_ready !== 1'b0 || bus_rdata !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h irq=%b required 0/0/0",
               bus_ready, bus_rdata, irq);
    end
    @(negedge clk); rst = 1'b0;
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_2000 || lat !== 1) begin
      failures++;
      $display("FAIL reset_status: got %h lat %0d required 00002000 lat 1", rd, lat);
    end
    bus_xfer(4'h8, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_0100) begin
      failures++;
      $display("FAIL reset_ctrl: got %h required 00000100", rd);
    end
  endtask

  task automatic test_fifo_order();
    logic [31:0] rd; int lat; logic r2;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    for (int i = 0; i < 3; i++) push(exp_b[i]);
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_0003) begin
      failures++;
      $display("FAIL order_status: got %h required 00000003", rd);
    end
    for (int i = 0; i < 3; i++) begin
      bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
      checks++;
      if (rd !== {24'h0, exp_b[i]} || lat !== 1 || r2 !== 1'b0) begin
        failures++;
        $display("FAIL order_data%0d: got %h lat %0d ready_after %b required %h lat 1 ready_after 0",
                 i, rd, lat, r2, {24'h0, exp_b[i]});
      end
    end
    bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h8000_0000) begin
      failures++;
      $display("FAIL order_empty: got %h required 80000000", rd);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd; int lat; logic r2;
    for (int i = 0; i < 17; i++) push(8'(i));
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_C010) begin
      failures++;
      $display("FAIL ovf_status: got %h required 0000c010", rd);
    end
    bus_xfer(4'h4, 4'b0010, 32'h0000_8000, rd, lat, r2);
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_4010) begin
      failures++;
      $display("FAIL ovf_clear: got %h required 00004010", rd);
    end
    // Push and pop on the same edge while full.
    @(negedge clk);
    bus_sel = 1'b1; bus_addr = 4'h0; bus_wstrb = 4'h0;
    rx_valid = 1'b1; rx_data = 8'hAA;
    @(posedge clk); #1;
    rx_valid = 1'b0; bus_sel = 1'b0;
    checks++;
    if (bus_ready !== 1'b1 || bus_rdata !== 32'h0000_0000) begin
      failures++;
      $display("FAIL full_pushpop: got ready=%b rdata=%h required 1 00000000", bus_ready, bus_rdata);
    end
    @(posedge clk); #1;
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_4010) begin
      failures++;
      $display("FAIL full_pushpop_status: got %h required 00004010", rd);
    end
    for (int i = 1; i < 17; i++) begin
      logic [31:0] e;
      e = (i == 16) ? 32'h0000_00AA : 32'(i);
      bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
      checks++;
      if (rd !== e) begin
        failures++;
        $display("FAIL ovf_drain%0d: got %h required %h", i, rd, e);
      end
    end
    bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h8000_0000) begin
      failures++;
      $display("FAIL ovf_drain_empty: got %h required 80000000", rd);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd; int lat; logic r2;
    bus_xfer(4'h8, 4'b1111, 32'h0000_0301, rd, lat, r2);
    bus_xfer(4'h8, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_0301) begin
      failures++;
      $display("FAIL ctrl_readback: got %h required 00000301", rd);
    end
    push(8'h01); push(8'h02); push(8'h03);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_lag: got %b required 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise: got %b required 1", irq);
    end
    bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (irq !== 1'b0 || rd !== 32'h0000_0001) begin
      failures++;
      $display("FAIL irq_fall: got irq=%b rdata=%h required 0 00000001", irq, rd);
    end
    bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
    bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
    // thresh 0 with enable set: irq on while empty.
    bus_xfer(4'h8, 4'b0011, 32'h0000_0001, rd, lat, r2);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_thresh0: got %b required 1", irq);
    end
    // Only lane 2 enabled: thresh[8] changes, the rest is kept.
    bus_xfer(4'h8, 4'b0100, 32'h0001_0500, rd, lat, r2);
    bus_xfer(4'h8, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0001_0001) begin
      failures++;
      $display("FAIL ctrl_lanes: got %h required 00010001", rd);
    end
    bus_xfer(4'h8, 4'b1111, 32'h0000_0000, rd, lat, r2);
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_disable: got %b required 0", irq);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat; logic r2;
    logic [7:0] q[$];
    for (int i = 0; i < 5; i++) begin
      push(8'(8'h10 + i));
      q.push_back(8'(8'h10 + i));
    end
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      push(8'(8'h80 + i));
      q.push_back(8'(8'h80 + i));
      e = q.pop_front();
      bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
      checks++;
      if (rd !== {24'h0, e}) begin
        failures++;
        $display("FAIL wrap_data%0d: got %h required %h", i, rd, {24'h0, e});
      end
    end
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_0005) begin
      failures++;
      $display("FAIL wrap_count: got %h required 00000005", rd);
    end
    // Flush with a byte arriving on the same edge: the byte is discarded.
    @(negedge clk);
    bus_sel = 1'b1; bus_addr = 4'h8; bus_wstrb = 4'b0001; bus_wdata = 32'h0000_0002;
    rx_valid = 1'b1; rx_data = 8'hEE;
    @(posedge clk); #1;
    rx_valid = 1'b0; bus_sel = 1'b0; bus_wstrb = 4'h0;
    @(posedge clk); #1;
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_2000) begin
      failures++;
      $display("FAIL flush_status: got %h required 00002000", rd);
    end
    bus_xfer(4'h8, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_0000) begin
      failures++;
      $display("FAIL flush_ctrl_read: got %h required 00000000", rd);
    end
  endtask

  task automatic test_reserved();
    logic [31:0] rd; int lat; logic r2;
    push(8'h77);
    bus_xfer(4'h0, 4'b1111, 32'h0000_0055, rd, lat, r2);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL data_write_ack: got lat %0d required 1", lat);
    end
    bus_xfer(4'hC, 4'b1111, 32'hFFFF_FFFF, rd, lat, r2);
    bus_xfer(4'hC, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0 || lat !== 1) begin
      failures++;
      $display("FAIL reserved_read: got %h lat %0d required 00000000 lat 1", rd, lat);
    end
    bus_xfer(4'h2, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL reserved_read2: got %h required 00000000", rd);
    end
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_0001) begin
      failures++;
      $display("FAIL reserved_status: got %h required 00000001", rd);
    end
    bus_xfer(4'h0, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_0077) begin
      failures++;
      $display("FAIL reserved_data: got %h required 00000077", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; logic r2;
    push(8'h21); push(8'h22);
    @(negedge clk);
    bus_sel = 1'b1; bus_addr = 4'h0; bus_wstrb = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (bus_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_ready: got %b required 1", bus_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus_ready !== 1'b0 || bus_rdata !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: got ready=%b rdata=%h required 0 00000000", bus_ready, bus_rdata);
    end
    bus_sel = 1'b0;
    @(negedge clk); rst = 1'b0;
    bus_xfer(4'h4, 4'h0, 32'h0, rd, lat, r2);
    checks++;
    if (rd !== 32'h0000_2000) begin
      failures++;
      $display("FAIL mid_status: got %h required 00002000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_irq();
    test_wrap();
    test_reserved();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
